// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, with flush abort.
module ex_muldiv_ctrl #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [2:0]         funct3_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               stall_o,
    output logic               ready_o,
    output logic [XLEN-1:0]    result_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         funct3_q;
    logic [RADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]    opa_q;          // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]  acc_q;          // product, or quotient in the low word
    logic [XLEN:0]      rem_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               special_q;
    logic [XLEN-1:0]    special_res_q;

    // ------------------------------------------------------------------
    // Operand decode in IDLE
    // ------------------------------------------------------------------
    logic            is_div;
    logic            signed_op1, signed_op2;
    logic            sign1, sign2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_by_zero, div_overflow;
    logic [XLEN-1:0] special_val;
    logic            accept;

    always_comb begin
        is_div       = funct3_i[2];
        signed_op1   = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
                       (funct3_i == F_DIV)  || (funct3_i == F_REM);
        signed_op2   = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
        sign1        = signed_op1 && op1_i[XLEN-1];
        sign2        = signed_op2 && op2_i[XLEN-1];
        abs1         = sign1 ? (~op1_i + 1'b1) : op1_i;
        abs2         = sign2 ? (~op2_i + 1'b1) : op2_i;
        div_by_zero  = is_div && (op2_i == '0);
        div_overflow = ((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
                       (op1_i == INT_MIN) && (op2_i == '1);
        // REM/REMU have funct3[1] set; DIV/DIVU do not.
        if (div_by_zero)
            special_val = funct3_i[1] ? op1_i : '1;
        else
            special_val = funct3_i[1] ? '0 : INT_MIN;
        accept       = (state_q == S_IDLE) && start_i && !flush_i;
    end

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] div_acc_next;
    logic [XLEN:0]     div_rem_next;

    always_comb begin
        mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_next     = {mul_sum, acc_q[XLEN-1:1]};

        div_shift    = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_trial    = {1'b0, div_shift} - {2'b00, opa_q};
        div_acc_next = acc_q;
        div_rem_next = div_shift;
        if (!div_trial[XLEN+1]) begin
            div_rem_next = div_trial[XLEN:0];
            div_acc_next = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_acc_next = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // State register and next-state / control outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != S_IDLE);
        stall_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    state_d = (div_by_zero || div_overflow) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall_o = 1'b1;
                if (flush_i)                state_d = S_IDLE;
                else if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: datapath registers are reset too, so a reset mid-op leaves no
    // stale operand or result visible afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            funct3_q      <= '0;
            waddr_q       <= '0;
            opa_q         <= '0;
            acc_q         <= '0;
            rem_q         <= '0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
        end else if (accept) begin
            cnt_q         <= '0;
            funct3_q      <= funct3_i;
            waddr_q       <= waddr_i;
            opa_q         <= is_div ? abs2 : abs1;
            acc_q         <= {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
            rem_q         <= '0;
            neg_res_q     <= sign1 ^ sign2;
            neg_rem_q     <= sign1;
            special_q     <= div_by_zero || div_overflow;
            special_res_q <= special_val;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + 1'b1;
            if (funct3_q[2]) begin
                acc_q <= div_acc_next;
                rem_q <= div_rem_next;
            end else begin
                acc_q <= mul_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and write-back in DONE
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        product   = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quotient  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        remainder = neg_rem_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
        if (special_q)                 final_res = special_res_q;
        else if (funct3_q == F_MUL)    final_res = product[XLEN-1:0];
        else if (!funct3_q[2])         final_res = product[2*XLEN-1:XLEN];
        else if (!funct3_q[1])         final_res = quotient;
        else                           final_res = remainder;

        ready_o     = (state_q == S_DONE);
        reg_we_o    = ready_o;
        result_o    = ready_o ? final_res : '0;
        reg_waddr_o = ready_o ? waddr_q : '0;
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl: arithmetic results,
// latency, stall, special cases, flush abort, reset abort and busy-ignore.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  waddr_i;
    logic        flush_i;
    logic        busy_o, stall_o, ready_o, reg_we_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .funct3_i    (funct3_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .waddr_i     (waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .stall_o     (stall_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one op in the current IDLE cycle and follows it to write-back.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int   edges;
        logic got;
        logic stall_ok;
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = f3;
        op1_i    = a;
        op2_i    = b;
        waddr_i  = rd;
        #1 check({tag, " stall_req"}, 32'(stall_o), 32'd1);
        edges    = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (!got && edges < 60) begin
            @(posedge clk);
            edges++;
            #1 start_i = 1'b0;
            @(negedge clk);
            if (ready_o) got = 1'b1;
            else if (!stall_o || !busy_o) stall_ok = 1'b0;
        end
        check({tag, " ready_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(edges), 32'(lat));
        check({tag, " result"}, result_o, exp);
        check({tag, " waddr"}, 32'(reg_waddr_o), 32'(rd));
        check({tag, " we"}, 32'(reg_we_o), 32'd1);
        check({tag, " stall_done"}, 32'(stall_o), 32'd0);
        check({tag, " stall_hold"}, 32'(stall_ok), 32'd1);
        @(negedge clk);
        check({tag, " ready_drop"}, 32'(ready_o), 32'd0);
        check({tag, " result_zero"}, result_o, 32'd0);
        check({tag, " idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int pulses;
        int waited;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        funct3_i = 3'b000;
        op1_i    = '0;
        op2_i    = '0;
        waddr_i  = '0;
        flush_i  = 1'b0;
        #1;
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst ready", 32'(ready_o), 32'd0);
        check("rst we", 32'(reg_we_o), 32'd0);
        check("rst result", result_o, 32'd0);
        check("rst waddr", 32'(reg_waddr_o), 32'd0);
        check("rst stall", 32'(stall_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic, back-to-back
        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 33);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 33);
        run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,        5'd14, 32'hFFFF_FFFF, 33);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd15, 32'hFFFF_FFFD, 33);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd16, 32'hFFFF_FFFF, 33);
        run_op("divu",   3'b101, 32'd100,      32'd7,        5'd17, 32'd14,        33);
        run_op("remu",   3'b111, 32'd100,      32'd7,        5'd18, 32'd2,         33);
        run_op("mul_big", 3'b000, 32'h0001_2345, 32'h0000_1000, 5'd19, 32'h1234_5000, 33);

        // Special cases complete in one cycle
        run_op("div0",   3'b100, 32'd5,        32'd0,        5'd20, 32'hFFFF_FFFF, 1);
        run_op("remu0",  3'b111, 32'd5,        32'd0,        5'd21, 32'd5,         1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0,         1);

        // Flush at counter 10
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = 3'b101;
        op1_i    = 32'd100;
        op2_i    = 32'd7;
        waddr_i  = 5'd4;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush busy_calc", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush idle", 32'(busy_o), 32'd0);
        check("flush no_ready", 32'(ready_o), 32'd0);
        check("flush no_we", 32'(reg_we_o), 32'd0);
        run_op("post_flush", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33);

        // Flush together with start in IDLE rejects the op
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        #1 check("flush_start stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_start idle", 32'(busy_o), 32'd0);

        // Reset mid-CALC
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = 3'b000;
        op1_i    = 32'd9;
        op2_i    = 32'd9;
        waddr_i  = 5'd7;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst busy", 32'(busy_o), 32'd0);
        check("arst stall", 32'(stall_o), 32'd0);
        check("arst ready", 32'(ready_o), 32'd0);
        check("arst result", result_o, 32'd0);
        check("arst waddr", 32'(reg_waddr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 3'b000, 32'd9, 32'd9, 5'd8, 32'd81, 33);

        // Start while busy is ignored
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = 3'b011;
        op1_i    = 32'h0001_0000;
        op2_i    = 32'h0001_0000;
        waddr_i  = 5'd3;
        @(posedge clk);
        #1;
        funct3_i = 3'b101;
        op1_i    = 32'd100;
        op2_i    = 32'd7;
        waddr_i  = 5'd9;
        repeat (20) @(posedge clk);
        #1 start_i = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!ready_o && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("busy_ign ready", 32'(ready_o), 32'd1);
        check("busy_ign result", result_o, 32'd1);
        check("busy_ign waddr", 32'(reg_waddr_o), 32'd3);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check("busy_ign single_wb", 32'(pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
